// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared raster timing constants for the VGA timing generator and for the
//   pixel-source blocks that need to know the visible area.
//   - VGA640_*  : 640x480@60 (25.175 MHz pixel clock), negative syncs
//   - SVGA800_* : 800x600@60 (40 MHz pixel clock), positive syncs
//   seg_total() sums the four segments of one axis.
package vga_timing_pkg;

    localparam int unsigned VGA640_H_VISIBLE  = 640;
    localparam int unsigned VGA640_H_FRONT    = 16;
    localparam int unsigned VGA640_H_SYNC     = 96;
    localparam int unsigned VGA640_H_BACK     = 48;
    localparam int unsigned VGA640_V_VISIBLE  = 480;
    localparam int unsigned VGA640_V_FRONT    = 10;
    localparam int unsigned VGA640_V_SYNC     = 2;
    localparam int unsigned VGA640_V_BACK     = 33;
    localparam bit          VGA640_HSYNC_ACT  = 1'b0;
    localparam bit          VGA640_VSYNC_ACT  = 1'b0;

    localparam int unsigned SVGA800_H_VISIBLE = 800;
    localparam int unsigned SVGA800_H_FRONT   = 40;
    localparam int unsigned SVGA800_H_SYNC    = 128;
    localparam int unsigned SVGA800_H_BACK    = 88;
    localparam int unsigned SVGA800_V_VISIBLE = 600;
    localparam int unsigned SVGA800_V_FRONT   = 1;
    localparam int unsigned SVGA800_V_SYNC    = 4;
    localparam int unsigned SVGA800_V_BACK    = 23;
    localparam bit          SVGA800_HSYNC_ACT = 1'b1;
    localparam bit          SVGA800_VSYNC_ACT = 1'b1;

    function automatic int unsigned seg_total(input int unsigned visible,
                                              input int unsigned front,
                                              input int unsigned sync,
                                              input int unsigned back);
        return visible + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_pixel_prescaler.sv
// vga_pixel_prescaler
//   Divides the system clock into a one-clock pixel strobe.
//   Ports:
//     clk      - system clock
//     reset    - asynchronous active-high reset (prescaler to 0)
//     enable   - low holds the prescaler count and suppresses the strobe
//     pixel_en - high for one clock in every CLK_DIV enabled clocks
module vga_pixel_prescaler #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic pixel_en
);

    localparam int unsigned    PW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]  P_LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] p;

    // Combinational from p so the counters advance in the same clock the
    // strobe is seen; with CLK_DIV=1 p stays 0 and the strobe equals enable.
    assign pixel_en = enable && (p == P_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p <= '0;
        end else if (enable) begin
            p <= (p == P_LAST) ? '0 : p + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised raster timing generator: pixel strobe, x/y counters, sync,
//   blank and line/frame start pulses.
//   Ports:
//     clk         - system clock, all logic on the rising edge
//     reset       - asynchronous active-high reset
//     enable      - low freezes prescaler, counters and outputs
//     pixel_en    - one-clock strobe, the clock in which x/y advance
//     x, y        - current raster position
//     hsync/vsync - registered syncs, active level set by *SYNC_ACTIVE
//     blank       - high outside the visible area
//     line_start  - one clock after the edge where x wraps to 0
//     frame_start - one clock after the edge where x and y wrap to 0
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 2,
    parameter int unsigned H_VISIBLE    = VGA640_H_VISIBLE,
    parameter int unsigned H_FRONT      = VGA640_H_FRONT,
    parameter int unsigned H_SYNC       = VGA640_H_SYNC,
    parameter int unsigned H_BACK       = VGA640_H_BACK,
    parameter int unsigned V_VISIBLE    = VGA640_V_VISIBLE,
    parameter int unsigned V_FRONT      = VGA640_V_FRONT,
    parameter int unsigned V_SYNC       = VGA640_V_SYNC,
    parameter int unsigned V_BACK       = VGA640_V_BACK,
    parameter bit          HSYNC_ACTIVE = VGA640_HSYNC_ACT,
    parameter bit          VSYNC_ACTIVE = VGA640_VSYNC_ACT,
    parameter int unsigned X_WIDTH      = 10,
    parameter int unsigned Y_WIDTH      = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    output logic               pixel_en,
    output logic [X_WIDTH-1:0] x,
    output logic [Y_WIDTH-1:0] y,
    output logic               hsync,
    output logic               vsync,
    output logic               blank,
    output logic               line_start,
    output logic               frame_start
);

    localparam int unsigned H_TOTAL = seg_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL = seg_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
    localparam int unsigned CW      = ((X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH) + 1;

    localparam logic [X_WIDTH-1:0] X_LAST   = X_WIDTH'(H_TOTAL - 1);
    localparam logic [Y_WIDTH-1:0] Y_LAST   = Y_WIDTH'(V_TOTAL - 1);
    localparam logic [CW-1:0]      H_VIS_C  = CW'(H_VISIBLE);
    localparam logic [CW-1:0]      HS_START = CW'(H_VISIBLE + H_FRONT);
    localparam logic [CW-1:0]      HS_END   = CW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CW-1:0]      V_VIS_C  = CW'(V_VISIBLE);
    localparam logic [CW-1:0]      VS_START = CW'(V_VISIBLE + V_FRONT);
    localparam logic [CW-1:0]      VS_END   = CW'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [X_WIDTH-1:0] next_x;
    logic [Y_WIDTH-1:0] next_y;
    logic [CW-1:0]      nx;
    logic [CW-1:0]      ny;
    logic               x_wrap;
    logic               y_wrap;
    logic               in_hs;
    logic               in_vs;
    logic               in_blank;

    vga_pixel_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .pixel_en (pixel_en)
    );

    always_comb begin
        next_x = x;
        next_y = y;
        x_wrap = (x == X_LAST);
        y_wrap = (y == Y_LAST);
        if (pixel_en) begin
            if (x_wrap) begin
                next_x = '0;
                next_y = y_wrap ? '0 : y + 1'b1;
            end else begin
                next_x = x + 1'b1;
            end
        end
    end

    // Decode from the next position so sync/blank register on the same edge
    // as the counters; without a strobe next == current and they hold.
    always_comb begin
        nx       = CW'(next_x);
        ny       = CW'(next_y);
        in_hs    = (nx >= HS_START) && (nx < HS_END);
        in_vs    = (ny >= VS_START) && (ny < VS_END);
        in_blank = (nx >= H_VIS_C) || (ny >= V_VIS_C);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x           <= '0;
            y           <= '0;
            hsync       <= ~HSYNC_ACTIVE;
            vsync       <= ~VSYNC_ACTIVE;
            blank       <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            x           <= next_x;
            y           <= next_y;
            hsync       <= in_hs ? HSYNC_ACTIVE : ~HSYNC_ACTIVE;
            vsync       <= in_vs ? VSYNC_ACTIVE : ~VSYNC_ACTIVE;
            blank       <= in_blank;
            line_start  <= pixel_en && x_wrap;
            frame_start <= pixel_en && x_wrap && y_wrap;
        end
    end

endmodule
